// File: rtl/riscv_prefetch_ctrl_if.sv
// Bus bundle for the instruction prefetch controller: core-side control,
// fetch-FIFO push port and instruction memory request/response channel.
interface riscv_prefetch_ctrl_if;
  logic        req_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        fifo_ready_i;
  logic        fifo_valid_o;
  logic [31:0] fifo_addr_o;
  logic [31:0] fifo_rdata_o;
  logic        fifo_clear_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        busy_o;

  // Controller side
  modport slave (
    input  req_i, branch_i, branch_addr_i, fifo_ready_i,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    output fifo_valid_o, fifo_addr_o, fifo_rdata_o, fifo_clear_o,
    output instr_req_o, instr_addr_o, busy_o
  );

  // Environment side (core, FIFO and memory)
  modport master (
    output req_i, branch_i, branch_addr_i, fifo_ready_i,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    input  fifo_valid_o, fifo_addr_o, fifo_rdata_o, fifo_clear_o,
    input  instr_req_o, instr_addr_o, busy_o
  );
endinterface

// File: rtl/riscv_prefetch_ctrl.sv
// Instruction prefetch controller: issues one word request at a time to
// instruction memory, passes responses straight into the fetch FIFO and
// handles redirects (branches) including aborting an in-flight response.
module riscv_prefetch_ctrl #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input logic                  clk,
  input logic                  rst_n,
  riscv_prefetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StWaitGnt,
    StWaitRvalid,
    StWaitAborted
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] tag_addr_q, tag_addr_d;
  logic        first_q, first_d;
  logic        active_q;

  logic        branch;
  logic        seq_ok;
  logic        pending;
  logic [31:0] branch_word;
  logic [31:0] branch_half;
  logic [31:0] req_addr;
  logic [31:0] req_tag;
  logic [31:0] req_next;
  logic        req_first;
  logic        issue;
  logic        push;

  // Select the address and tag of a request that would be issued this cycle
  always_comb begin
    // active_q keeps every output quiet for the first cycle after reset release
    branch      = active_q & bus.branch_i;
    seq_ok      = active_q & bus.req_i & bus.fifo_ready_i;
    branch_word = bus.branch_addr_i & ~32'h3;
    branch_half = bus.branch_addr_i & ~32'h1;
    // In these states fetch_addr_q/tag_addr_q hold a request not yet granted
    pending     = (state_q == StWaitGnt) || (state_q == StWaitAborted);
    req_addr    = branch ? branch_word : fetch_addr_q;
    req_tag     = branch ? branch_half : (pending ? tag_addr_q : fetch_addr_q);
    req_first   = branch | (pending & first_q);
    req_next    = req_addr + 32'd4;
  end

  // Next-state logic and issue/push decisions
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    tag_addr_d   = tag_addr_q;
    first_d      = first_q;
    issue        = 1'b0;
    push         = 1'b0;

    unique case (state_q)
      StIdle: begin
        issue = branch | seq_ok;
      end
      StWaitGnt: begin
        issue = 1'b1;
      end
      StWaitRvalid: begin
        if (bus.instr_rvalid_i) begin
          push    = ~branch;
          issue   = branch | seq_ok;
          first_d = 1'b0;
          if (!issue) begin
            state_d = StIdle;
          end
        end else if (branch) begin
          // Stale response still owed; remember the target until it returns
          state_d      = StWaitAborted;
          fetch_addr_d = branch_word;
          tag_addr_d   = branch_half;
          first_d      = 1'b1;
        end
      end
      StWaitAborted: begin
        if (bus.instr_rvalid_i) begin
          issue = 1'b1;
        end else if (branch) begin
          fetch_addr_d = branch_word;
          tag_addr_d   = branch_half;
          first_d      = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (issue) begin
      tag_addr_d = req_tag;
      first_d    = req_first;
      if (bus.instr_gnt_i) begin
        state_d      = StWaitRvalid;
        fetch_addr_d = req_next;
      end else begin
        // Hold the request address stable until granted
        state_d      = StWaitGnt;
        fetch_addr_d = req_addr;
      end
    end
  end

  // Output drive
  always_comb begin
    bus.instr_req_o  = issue;
    bus.instr_addr_o = req_addr;
    bus.fifo_valid_o = push;
    bus.fifo_addr_o  = push ? tag_addr_q : 32'h0;
    bus.fifo_rdata_o = push ? bus.instr_rdata_i : 32'h0;
    bus.fifo_clear_o = branch;
    bus.busy_o       = (state_q != StIdle);
  end

  // State and address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      fetch_addr_q <= BOOT_ADDR;
      tag_addr_q   <= BOOT_ADDR;
      first_q      <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      tag_addr_q   <= tag_addr_d;
      first_q      <= first_d;
      active_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_prefetch_ctrl.sv
// Randomised bench for riscv_prefetch_ctrl: a simple memory model answers
// requests, a program-counter style reference model predicts requests and
// FIFO pushes, and a monitor checks every push against a scoreboard queue.
module tb_riscv_prefetch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_prefetch_ctrl_if bus_if ();

  riscv_prefetch_ctrl #(.BOOT_ADDR(32'h0000_0080)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } push_t;

  push_t exp_q[$];
  int    n_cmp = 0;
  int    n_mis = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: next fetch address/tag and the outstanding word
  logic [31:0] m_next_addr, m_next_tag, m_out_addr, m_out_tag;
  bit          m_out, m_out_killed, m_redir, m_held, m_gate;

  // Memory model state
  bit          mem_pend, rv_from_mem;
  logic [31:0] mem_addr;
  int          mem_lat;

  task automatic model_reset();
    m_next_addr = 32'h80;
    m_next_tag  = 32'h80;
    m_out       = 0;
    m_out_killed = 0;
    m_redir     = 0;
    m_held      = 0;
    m_gate      = 1;
    exp_q.delete();
  endtask

  // Stimulus, memory and reference model
  initial begin
    bit          br, exp_req, in_reset;
    logic [31:0] ba;
    mem_pend = 0;
    mem_lat  = 0;
    mem_addr = 0;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      in_reset = (cyc < 3) || (cyc >= 1500 && cyc < 1503);
      rst_n = !in_reset;
      bus_if.req_i        = ($urandom_range(0, 99) < 85);
      bus_if.fifo_ready_i = ($urandom_range(0, 99) < 75);
      bus_if.branch_i     = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 3) == 0) bus_if.branch_addr_i = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      else bus_if.branch_addr_i = $urandom;
      rv_from_mem = mem_pend && (mem_lat == 0);
      bus_if.instr_rvalid_i = rv_from_mem || (!mem_pend && $urandom_range(0, 99) < 5);
      bus_if.instr_rdata_i  = rv_from_mem ? mem_data(mem_addr) : $urandom;
      bus_if.instr_gnt_i    = (!mem_pend || rv_from_mem) && ($urandom_range(0, 99) < 60);

      @(negedge clk);
      if (!rst_n) begin
        check("rst_req", {31'b0, bus_if.instr_req_o}, 32'h0);
        check("rst_addr", bus_if.instr_addr_o, 32'h80);
        check("rst_valid", {31'b0, bus_if.fifo_valid_o}, 32'h0);
        check("rst_faddr", bus_if.fifo_addr_o, 32'h0);
        check("rst_fdata", bus_if.fifo_rdata_o, 32'h0);
        check("rst_clear", {31'b0, bus_if.fifo_clear_o}, 32'h0);
        check("rst_busy", {31'b0, bus_if.busy_o}, 32'h0);
        model_reset();
      end else begin
        check("busy", {31'b0, bus_if.busy_o}, {31'b0, m_out || m_held});
        br = bus_if.branch_i && !m_gate;
        ba = bus_if.branch_addr_i;
        if (bus_if.instr_rvalid_i && m_out) begin
          if (!m_out_killed && !br) exp_q.push_back('{addr: m_out_tag, data: mem_data(m_out_addr)});
          m_out = 0;
        end
        if (br) begin
          if (m_out) m_out_killed = 1;
          m_next_addr = ba & ~32'h3;
          m_next_tag  = ba & ~32'h1;
          m_redir     = 1;
        end
        exp_req = !m_gate && !m_out &&
                  (br || m_held || m_redir || (bus_if.req_i && bus_if.fifo_ready_i));
        check("instr_req", {31'b0, bus_if.instr_req_o}, {31'b0, exp_req});
        check("fifo_clear", {31'b0, bus_if.fifo_clear_o}, {31'b0, br});
        if (exp_req) check("instr_addr", bus_if.instr_addr_o, m_next_addr);
        if (exp_req && bus_if.instr_gnt_i) begin
          m_out        = 1;
          m_out_killed = 0;
          m_out_addr   = m_next_addr;
          m_out_tag    = m_next_tag;
          m_next_addr  = m_next_addr + 32'd4;
          m_next_tag   = m_next_addr;
          m_redir      = 0;
          m_held       = 0;
        end else begin
          m_held = exp_req;
        end
        m_gate = 0;
      end

      if (rv_from_mem) mem_pend = 0;
      else if (mem_pend) mem_lat--;
      if (rst_n && bus_if.instr_req_o && bus_if.instr_gnt_i) begin
        mem_pend = 1;
        mem_addr = bus_if.instr_addr_o;
        mem_lat  = $urandom_range(0, 2);
      end
    end
    @(posedge clk);
    check("leftover_pushes", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Push monitor: pops the scoreboard whenever the DUT pushes a word
  initial begin
    push_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus_if.fifo_valid_o) begin
        check("push_vs_clear", {31'b0, bus_if.fifo_clear_o}, 32'h0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_push: got addr %h data %h expected no push",
                   bus_if.fifo_addr_o, bus_if.fifo_rdata_o);
        end else begin
          e = exp_q.pop_front();
          check("push_addr", bus_if.fifo_addr_o, e.addr);
          check("push_data", bus_if.fifo_rdata_o, e.data);
        end
      end
    end
  end

endmodule

// File: doc/riscv_prefetch_ctrl.md
RISCV_PREFETCH_CTRL -- requirements
Module: riscv_prefetch_ctrl

Interface
REQ-001 Parameter: BOOT_ADDR, 32'h0000_0080, fetch address after reset.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_i  in  1  fetch enable from core controller.
REQ-005 branch_i  in  1  one-cycle redirect strobe.
REQ-006 branch_addr_i  in  32  redirect target, halfword aligned, bit0 ignored.
REQ-007 fifo_ready_i  in  1  downstream fetch FIFO can accept one more word plus one in flight.
REQ-008 fifo_valid_o  out  1  word pushed to fetch FIFO this cycle.
REQ-009 fifo_addr_o  out  32  address tagged to pushed word.
REQ-010 fifo_rdata_o  out  32  pushed instruction word.
REQ-011 fifo_clear_o  out  1  flush downstream FIFO.
REQ-012 instr_req_o  out  1  memory request.
REQ-013 instr_addr_o  out  32  memory word address, bits[1:0] always 2'b00.
REQ-014 instr_gnt_i  in  1  memory grant.
REQ-015 instr_rvalid_i  in  1  memory response valid.
REQ-016 instr_rdata_i  in  32  memory response data.
REQ-017 busy_o  out  1  transaction outstanding (state != IDLE).

Function
REQ-018 FSM states: IDLE, WAIT_GNT, WAIT_RVALID, WAIT_ABORTED; at most one transaction outstanding.
REQ-019 Registers: fetch_addr_q (word address of next request), tag_addr_q (address tagged to the in-flight word), first_q (in-flight word is first after redirect).
REQ-020 Issue condition: branch_i, or (req_i and fifo_ready_i); instr_req_o asserts combinationally in the issue cycle.
REQ-021 instr_addr_o = branch_i ? {branch_addr_i[31:2],2'b00} : fetch_addr_q.
REQ-022 IDLE: on issue, go WAIT_RVALID if instr_gnt_i, else WAIT_GNT.
REQ-023 WAIT_GNT: instr_req_o held 1 and instr_addr_o held stable; on instr_gnt_i go WAIT_RVALID.
REQ-024 Branch in WAIT_GNT: instr_addr_o switches to the branch word address in the same cycle; request stays asserted.
REQ-025 On grant, fetch_addr_q <= granted address + 4; tag_addr_q <= granted address, except after a redirect, when tag_addr_q <= {branch_addr_i[31:1],1'b0}.
REQ-026 WAIT_RVALID, instr_rvalid_i without branch_i: fifo_valid_o=1, fifo_rdata_o=instr_rdata_i, fifo_addr_o=tag_addr_q (zero-latency pass-through).
REQ-027 Same cycle as that response: if issue condition holds, request next word back-to-back (REQ-022 rules); otherwise go IDLE.
REQ-028 Branch in WAIT_RVALID with instr_rvalid_i: response discarded (fifo_valid_o=0); branch request issued the same cycle.
REQ-029 Branch in WAIT_RVALID without instr_rvalid_i: go WAIT_ABORTED; no request until the stale response returns.
REQ-030 WAIT_ABORTED: stale rvalid dropped; in that cycle issue the pending redirect (target latched in fetch_addr_q/tag_addr_q); branch_i in WAIT_ABORTED overwrites the latched target.
REQ-031 fifo_clear_o = branch_i, same cycle; fifo_valid_o is never 1 when fifo_clear_o is 1.
REQ-032 fifo_ready_i=0 blocks new sequential issues only; outstanding responses are always pushed.
REQ-033 req_i deassert: no new sequential request; outstanding transaction completes and pushes normally.
REQ-034 Address arithmetic mod 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000, no error.
REQ-035 rvalid in IDLE or WAIT_GNT is illegal; it is ignored and no push occurs.

Reset
REQ-036 Reset: state IDLE; fetch_addr_q=BOOT_ADDR; tag_addr_q=BOOT_ADDR; first_q=0.
REQ-037 While in reset, and on the first cycle after, all outputs are 0 except instr_addr_o=BOOT_ADDR.
REQ-038 Reset mid-transaction returns to IDLE immediately; a late rvalid after release is ignored per REQ-035.

Verification
REQ-039 Release reset, req_i=1, fifo_ready_i=1, gnt same cycle, rvalid next cycle -> requests at 0x80, 0x84, 0x88 back-to-back; pushes tagged 0x80, 0x84, 0x88.
REQ-040 gnt held low 3 cycles -> instr_req_o=1 and instr_addr_o=0x80 stable for 4 cycles; single push of 0x80.
REQ-041 branch_i to 0x1002 while in WAIT_RVALID, rvalid 2 cycles later -> stale word dropped; fifo_clear_o pulses once; next request to 0x1000; push tagged 0x1002; following request to 0x1004.
REQ-042 branch_i coincident with rvalid -> no push that cycle; request to the branch word address issued the same cycle.
REQ-043 fifo_ready_i=0 -> in-flight word still pushed; no new request until fifo_ready_i=1.
REQ-044 Sequential fetch at 0xFFFF_FFFC -> next request at 0x0000_0000.
